// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential shift-add unsigned multiplier
// One multiplier bit per cycle, fixed WIDTH-cycle latency, valid/ready on both sides.
module shift_add_multiplier #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] number,
   input  logic [WIDTH-1:0] multiplier,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result2,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [CW-1:0]      count_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;
   logic [WIDTH-1:0]   result_q;
   logic [WIDTH-1:0]   result2_q;

   logic [2*WIDTH-1:0] acc_d;
   logic               last_step;

   assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign last_step = (count_q == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         result_q    <= '0;
         result2_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  mcand_q    <= {{WIDTH{1'b0}}, number};
                  mplier_q   <= multiplier;
                  acc_q      <= '0;
                  count_q    <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_BUSY;
               end
            end
            S_BUSY: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               count_q  <= count_q + CW'(1);
               // No early exit on zero operands: latency is always WIDTH cycles.
               if (last_step) begin
                  {result2_q, result_q} <= acc_d;
                  out_valid_q           <= 1'b1;
                  busy_q                <= 1'b0;
                  state_q               <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign result    = result_q;
   assign result2   = result2_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - directed self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] number;
   logic [15:0] multiplier;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [15:0] result2;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   shift_add_multiplier #(.WIDTH(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .number     (number),
      .multiplier (multiplier),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .result2    (result2),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents operands for one edge (accept edge = cycle 0), then scrambles the ports.
   task automatic start(input logic [15:0] a, input logic [15:0] b);
      number     = a;
      multiplier = b;
      in_valid   = 1'b1;
      tick();
      in_valid   = 1'b0;
      number     = 16'hA5A5;
      multiplier = 16'h5A5A;
      check("accept_busy", {31'd0, busy}, 32'd1);
      check("accept_in_ready", {31'd0, in_ready}, 32'd0);
   endtask

   // Runs edges 1..16 and checks the product appears exactly after edge 16.
   task automatic finish_job(input logic [15:0] lo, input logic [15:0] hi);
      for (int i = 1; i < 16; i++) begin
         tick();
         check("early_out_valid", {31'd0, out_valid}, 32'd0);
         check("busy_in_ready", {31'd0, in_ready}, 32'd0);
      end
      tick();
      check("done_out_valid", {31'd0, out_valid}, 32'd1);
      check("done_in_ready", {31'd0, in_ready}, 32'd0);
      check("done_busy", {31'd0, busy}, 32'd0);
      check("result", {16'd0, result}, {16'd0, lo});
      check("result2", {16'd0, result2}, {16'd0, hi});
   endtask

   task automatic handshake(input logic [15:0] lo);
      tick();
      check("hs_out_valid", {31'd0, out_valid}, 32'd0);
      check("hs_in_ready", {31'd0, in_ready}, 32'd1);
      check("hs_result_kept", {16'd0, result}, {16'd0, lo});
   endtask

   initial begin
      reset      = 1'b0;
      in_valid   = 1'b0;
      number     = 16'd0;
      multiplier = 16'd0;
      out_ready  = 1'b1;
      tick();
      tick();
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_result", {result2, result}, 32'd0);
      reset = 1'b1;
      tick();
      tick();
      check("idle_stays", {30'd0, busy, in_ready}, 32'd1);

      // 9 * 1
      start(16'd9, 16'd1);
      finish_job(16'd9, 16'd0);
      handshake(16'd9);

      // 6 * 2 then 8 * 5, second accepted 18 edges after the first
      start(16'd6, 16'd2);
      finish_job(16'd12, 16'd0);
      handshake(16'd12);
      start(16'd8, 16'd5);
      finish_job(16'd40, 16'd0);
      handshake(16'd40);

      // Largest operands
      start(16'hFFFF, 16'hFFFF);
      finish_job(16'h0001, 16'hFFFE);
      handshake(16'h0001);

      // Zero multiplicand still takes full latency
      start(16'h0000, 16'h1234);
      finish_job(16'h0000, 16'h0000);
      handshake(16'h0000);

      // Backpressure: 0x1234 * 0x10 = 0x00012340
      out_ready = 1'b0;
      start(16'h1234, 16'h0010);
      finish_job(16'h2340, 16'h0001);
      in_valid   = 1'b1;
      number     = 16'h0003;
      multiplier = 16'h0003;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_product", {result2, result}, 32'h0001_2340);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      handshake(16'h2340);
      tick();
      check("bp_no_late_accept", {31'd0, busy}, 32'd0);
      check("bp_result2_kept", {16'd0, result2}, 32'd1);

      // Asynchronous reset in the middle of BUSY
      start(16'd100, 16'd100);
      for (int i = 1; i <= 8; i++) tick();
      check("pre_abort_busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_product", {result2, result}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("abort_no_valid", {31'd0, out_valid}, 32'd0);
      end
      reset = 1'b1;
      tick();
      check("post_abort_idle", {30'd0, busy, in_ready}, 32'd1);
      start(16'd3, 16'd7);
      finish_job(16'd21, 16'd0);
      handshake(16'd21);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
